// File: rtl/tape_symbol_encoder_pkg.sv
// Shared tape line-code constants: data-level table, framing markers, CRC polynomial.
package tape_symbol_encoder_pkg;

  localparam logic [3:0] MARK_A   = 4'b1010;
  localparam logic [3:0] MARK_B   = 4'b0101;
  localparam logic [7:0] CRC_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SOF,
    ST_PAYLOAD,
    ST_CRC,
    ST_FLUSH,
    ST_EOF
  } enc_state_t;

  function automatic logic [3:0] data_symbol(input logic [2:0] v);
    logic [3:0] s;
    case (v)
      3'd0:    s = 4'b0000;
      3'd1:    s = 4'b0001;
      3'd2:    s = 4'b0011;
      3'd3:    s = 4'b0111;
      3'd4:    s = 4'b1111;
      3'd5:    s = 4'b1110;
      3'd6:    s = 4'b1100;
      default: s = 4'b1000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tape_crc8.sv
// Combinational byte-wide CRC-8 update, MSB first, no reflection.
module tape_crc8
  import tape_symbol_encoder_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data_in;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/tape_symbol_encoder.sv
// Frames a byte stream into 4-bit tape symbols: preamble, SOF, payload, CRC-8, pad, EOF.
module tape_symbol_encoder
  import tape_symbol_encoder_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned FIFO_DEPTH   = 2048,
  parameter int unsigned FIFO_MARGIN  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [3:0]  fifow_data,
  output logic        fifow_request,
  input  logic        fifow_full,
  input  logic [10:0] fifow_used_words,
  output logic        frame_done,
  output logic        busy
);

  enc_state_t  state;
  logic [9:0]  gbuf;
  logic [3:0]  count;
  logic [7:0]  crc;
  logic [7:0]  crc_next;
  logic [15:0] idx;
  logic        wr_ok;
  logic        gb_emit;

  // Place a byte directly below the bits still waiting in the gearbox.
  function automatic logic [9:0] gb_load(input logic [9:0] b, input logic [3:0] n,
                                         input logic [7:0] d);
    logic [9:0] r;
    case (n)
      4'd0:    r = {d, 2'b00};
      4'd1:    r = {b[9], d, 1'b0};
      default: r = {b[9:8], d};
    endcase
    return r;
  endfunction

  tape_crc8 u_crc (
    .crc_in  (crc),
    .data_in (s_data),
    .crc_out (crc_next)
  );

  assign wr_ok   = !fifow_full && (fifow_used_words < 11'(FIFO_DEPTH - FIFO_MARGIN));
  assign s_ready = (state == ST_PAYLOAD) && (count < 4'd3);
  assign busy    = (state != ST_IDLE);
  assign gb_emit = ((state == ST_PAYLOAD) || (state == ST_CRC) || (state == ST_FLUSH)) &&
                   (count >= 4'd3) && wr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      gbuf          <= '0;
      count         <= '0;
      crc           <= '0;
      idx           <= '0;
      fifow_request <= 1'b0;
      fifow_data    <= '0;
      frame_done    <= 1'b0;
    end else begin
      fifow_request <= 1'b0;
      frame_done    <= 1'b0;
      if (gb_emit) begin
        fifow_request <= 1'b1;
        fifow_data    <= data_symbol(gbuf[9:7]);
        gbuf          <= {gbuf[6:0], 3'b000};
        count         <= count - 4'd3;
      end else begin
        case (state)
          ST_IDLE: begin
            if (s_valid) begin
              state <= ST_PREAMBLE;
              crc   <= '0;
              count <= '0;
              gbuf  <= '0;
              // First preamble symbol goes out on the same edge that sees s_valid.
              if (wr_ok) begin
                fifow_request <= 1'b1;
                fifow_data    <= MARK_A;
                idx           <= 16'd1;
              end else begin
                idx <= '0;
              end
            end
          end
          ST_PREAMBLE: begin
            if (wr_ok) begin
              fifow_request <= 1'b1;
              fifow_data    <= idx[0] ? MARK_B : MARK_A;
              if (idx == 16'(PREAMBLE_LEN - 1)) begin
                state <= ST_SOF;
                idx   <= '0;
              end else begin
                idx <= idx + 16'd1;
              end
            end
          end
          ST_SOF: begin
            if (wr_ok) begin
              fifow_request <= 1'b1;
              fifow_data    <= MARK_B;
              if (idx[0]) begin
                state <= ST_PAYLOAD;
                idx   <= '0;
              end else begin
                idx <= 16'd1;
              end
            end
          end
          ST_PAYLOAD: begin
            if (s_ready && s_valid) begin
              gbuf  <= gb_load(gbuf, count, s_data);
              count <= count + 4'd8;
              crc   <= crc_next;
              if (s_last) state <= ST_CRC;
            end
          end
          ST_CRC: begin
            if (count < 4'd3) begin
              gbuf  <= gb_load(gbuf, count, crc);
              count <= count + 4'd8;
              state <= ST_FLUSH;
            end
          end
          ST_FLUSH: begin
            // Remaining 1-2 bits leave as one symbol; lower bits are already zero.
            if (count == 4'd0) begin
              state <= ST_EOF;
              idx   <= '0;
            end else if ((count < 4'd3) && wr_ok) begin
              fifow_request <= 1'b1;
              fifow_data    <= data_symbol(gbuf[9:7]);
              gbuf          <= '0;
              count         <= '0;
              state         <= ST_EOF;
              idx           <= '0;
            end
          end
          ST_EOF: begin
            if (idx == 16'd2) begin
              state      <= ST_IDLE;
              frame_done <= 1'b1;
              idx        <= '0;
            end else if (wr_ok) begin
              fifow_request <= 1'b1;
              fifow_data    <= MARK_A;
              idx           <= idx + 16'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tape_symbol_encoder.sv
// Directed bench for tape_symbol_encoder with a capturing FIFO write-side model.
module tb_tape_symbol_encoder;

  localparam int unsigned PL = 4;
  localparam logic [3:0] SA = 4'b1010;
  localparam logic [3:0] SB = 4'b0101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [3:0]  fifow_data;
  logic        fifow_request;
  logic        fifow_full = 1'b0;
  logic [10:0] fifow_used_words = '0;
  logic        frame_done;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [3:0] wr_q[$];
  logic [3:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [43:0] d_a5;
  logic [43:0] d_3b;

  always #5 clk = ~clk;

  tape_symbol_encoder #(
    .PREAMBLE_LEN (PL),
    .FIFO_DEPTH   (2048),
    .FIFO_MARGIN  (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_last           (s_last),
    .s_ready          (s_ready),
    .fifow_data       (fifow_data),
    .fifow_request    (fifow_request),
    .fifow_full       (fifow_full),
    .fifow_used_words (fifow_used_words),
    .frame_done       (frame_done),
    .busy             (busy)
  );

  always @(negedge clk) begin
    if (fifow_request) wr_q.push_back(fifow_data);
    if (frame_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_exp(input logic [43:0] d, input int n);
    exp_q.delete();
    for (int i = 0; i < int'(PL); i++) exp_q.push_back((i % 2) ? SB : SA);
    exp_q.push_back(SB);
    exp_q.push_back(SB);
    for (int i = 0; i < n; i++) exp_q.push_back(d[4*n-1-4*i -: 4]);
    exp_q.push_back(SA);
    exp_q.push_back(SA);
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s_sym%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
  endtask

  task automatic send_bytes(input bit mark_last);
    int n;
    for (int i = 0; i < tx_q.size(); i++) begin
      s_data  = tx_q[i];
      s_last  = mark_last && (i == tx_q.size() - 1);
      s_valid = 1'b1;
      n = 0;
      while (!s_ready && n < 300) begin
        @(negedge clk);
        #1;
        n++;
      end
      check($sformatf("ready_byte%0d", i), 32'(s_ready), 1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      #1;
      if (frame_done) break;
      n++;
    end
    check({tag, "_done_seen"}, 32'(frame_done), 1);
    check({tag, "_busy_at_done"}, 32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    int n;
    int n0;
    d_a5 = {20'h0, 4'b1110, 4'b0001, 4'b0011, 4'b1000, 4'b0001, 4'b0000};
    d_3b = {4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b1000, 4'b1111,
            4'b1000, 4'b1111, 4'b0111, 4'b0000, 4'b1100};

    // Reset held for three cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_request", 32'(fifow_request), 0);
    check("rst_ready", 32'(s_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data", 32'(fifow_data), 0);
    check("rst_done", 32'(frame_done), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single byte 0xA5 frame, CRC 0x72; also first-symbol latency.
    wr_q.delete();
    d0 = done_cnt;
    s_data = 8'hA5; s_last = 1'b1; s_valid = 1'b1;
    @(posedge clk);
    #1;
    check("lat_request", 32'(fifow_request), 1);
    check("lat_data", 32'(fifow_data), 32'(SA));
    tx_q = '{8'hA5};
    send_bytes(1'b1);
    wait_done("a5");
    repeat (3) @(negedge clk);
    #1;
    check("a5_done_once", done_cnt - d0, 1);
    set_exp(d_a5, 6);
    compare_frame("a5");

    // Three-byte frame 00 FF 3C, CRC 0x63, one pad bit.
    wr_q.delete();
    d0 = done_cnt;
    tx_q = '{8'h00, 8'hFF, 8'h3C};
    send_bytes(1'b1);
    wait_done("b3");
    repeat (3) @(negedge clk);
    #1;
    check("b3_done_once", done_cnt - d0, 1);
    set_exp(d_3b, 11);
    compare_frame("b3");

    // Same frame with mid-payload back-pressure from used_words then from full.
    wr_q.delete();
    tx_q = '{8'h00, 8'hFF, 8'h3C};
    fork
      send_bytes(1'b1);
      begin
        n = 0;
        while (wr_q.size() < 8 && n < 300) begin
          @(negedge clk);
          #1;
          n++;
        end
        check("stall_reached", 32'(wr_q.size() >= 8), 1);
        fifow_used_words = 11'd2046;
        @(posedge clk);
        #1;
        n0 = wr_q.size();
        repeat (10) @(negedge clk);
        #1;
        check("stall_used_writes", wr_q.size(), n0);
        check("stall_busy", 32'(busy), 1);
        fifow_used_words = 11'd0;
        fifow_full = 1'b1;
        @(posedge clk);
        #1;
        n0 = wr_q.size();
        repeat (10) @(negedge clk);
        #1;
        check("stall_full_writes", wr_q.size(), n0);
        fifow_full = 1'b0;
      end
    join
    wait_done("stall");
    compare_frame("stall");

    // Input gap of 10 cycles after the first byte.
    wr_q.delete();
    tx_q = '{8'h00};
    send_bytes(1'b0);
    repeat (3) @(negedge clk);
    #1;
    n0 = wr_q.size();
    repeat (7) @(negedge clk);
    #1;
    check("gap_writes", wr_q.size(), n0);
    check("gap_ready", 32'(s_ready), 1);
    check("gap_busy", 32'(busy), 1);
    tx_q = '{8'hFF, 8'h3C};
    send_bytes(1'b1);
    wait_done("gap");
    compare_frame("gap");

    // Reset mid-payload abandons the frame; a new frame starts clean.
    wr_q.delete();
    d0 = done_cnt;
    tx_q = '{8'h00};
    send_bytes(1'b0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_request", 32'(fifow_request), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_ready", 32'(s_ready), 0);
    repeat (3) @(negedge clk);
    #1;
    check("mrst_no_done", done_cnt - d0, 0);
    check("mrst_no_writes", 32'(fifow_request), 0);
    wr_q.delete();
    tx_q = '{8'hA5};
    send_bytes(1'b1);
    wait_done("post");
    set_exp(d_a5, 6);
    compare_frame("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
